mig_apm_stat_gen: RTL and testbench

Per-DSID traffic statistics generator for the memory-controller path. It snoops AW/AR address handshakes on the AXI link that enters the MIG control plane. It counts requests and beats per DSID slot over a fixed sampling window. At each window end it streams the snapshot out as APM_VALID/APM_ADDR/APM_DATA write records, which are the transmitting end of the APM interface the control plane consumes.

---
 rtl/mig_apm_stat_gen.sv | 183 ++++++++++++++++++
 tb/tb_mig_apm_stat_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mig_apm_stat_gen.sv
// -----------------------------------------------------------------------------
// mig_apm_stat_gen
//
// Per-DSID traffic statistics generator for the MIG control plane. It watches
// AW/AR address handshakes on the AXI link and accumulates four saturating
// 32-bit counters per DSID slot:
//   metric 0 : read requests
//   metric 1 : write requests
//   metric 2 : read beats  (arlen+1)
//   metric 3 : write beats (awlen+1)
// At the end of each sampling window the counters are copied into snapshot
// registers and cleared. The snapshot is then streamed out as one APM write
// record per cycle, slot-major (record i = slot*4 + metric).
//
// Handshake semantics: this block only snoops. An address event is counted in
// the cycle where valid and ready are both high. It never drives ready, and
// the APM side has no backpressure: APM_VALID is a pure strobe, one record
// per cycle.
//
// Ports
//   aclk, aresetn              clock, synchronous active-low reset
//   s_axi_aw{valid,ready,user,len}   snooped write-address channel
//   s_axi_ar{valid,ready,user,len}   snooped read-address channel
//   APM_VALID/APM_ADDR/APM_DATA      registered record stream
//   overrun                    sticky flag: a window ended during an emission
// -----------------------------------------------------------------------------
module mig_apm_stat_gen #(
    parameter int unsigned C_DSID_WIDTH    = 16,
    parameter int unsigned C_NUM_SLOTS     = 4,
    parameter int unsigned C_WINDOW_CYCLES = 1024,
    parameter logic [31:0] C_APM_BASE      = 32'h0000_0000
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    s_axi_awvalid,
    input  logic                    s_axi_awready,
    input  logic [C_DSID_WIDTH-1:0] s_axi_awuser,
    input  logic [7:0]              s_axi_awlen,
    input  logic                    s_axi_arvalid,
    input  logic                    s_axi_arready,
    input  logic [C_DSID_WIDTH-1:0] s_axi_aruser,
    input  logic [7:0]              s_axi_arlen,
    output logic                    APM_VALID,
    output logic [31:0]             APM_ADDR,
    output logic [31:0]             APM_DATA,
    output logic                    overrun
);

    localparam int unsigned NUM_REC = 4 * C_NUM_SLOTS;
    localparam int unsigned IDX_W   = $clog2(NUM_REC);
    localparam int unsigned WC_W    = $clog2(C_WINDOW_CYCLES);

    localparam int M_RD_REQ  = 0;
    localparam int M_WR_REQ  = 1;
    localparam int M_RD_BEAT = 2;
    localparam int M_WR_BEAT = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t             state_q;
    logic [WC_W-1:0]    wc_q;
    logic [IDX_W-1:0]   idx_q;
    logic               overrun_q;
    logic               vld_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;
    logic [31:0]        live_q   [NUM_REC];
    logic [31:0]        snap_q   [NUM_REC];
    logic [31:0]        live_nxt [NUM_REC];

    logic               ar_hs;
    logic               aw_hs;
    logic [8:0]         ar_beats;
    logic [8:0]         aw_beats;
    logic               win_end;
    logic [IDX_W-1:0]   idx_nxt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [8:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {24'd0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    assign ar_hs    = s_axi_arvalid && s_axi_arready;
    assign aw_hs    = s_axi_awvalid && s_axi_awready;
    assign ar_beats = {1'b0, s_axi_arlen} + 9'd1;
    assign aw_beats = {1'b0, s_axi_awlen} + 9'd1;
    assign win_end  = (wc_q == WC_W'(C_WINDOW_CYCLES - 1));
    assign idx_nxt  = idx_q + IDX_W'(1);

    // Live counters plus this cycle's events. AR and AW touch disjoint
    // metrics, so a same-slot AR+AW pair needs no arbitration. Tags that do
    // not decode to any slot simply match nothing.
    always_comb begin
        live_nxt = live_q;
        for (int s = 0; s < C_NUM_SLOTS; s++) begin
            if (ar_hs && (s_axi_aruser == C_DSID_WIDTH'(s))) begin
                live_nxt[4*s+M_RD_REQ]  = sat_add(live_q[4*s+M_RD_REQ], 9'd1);
                live_nxt[4*s+M_RD_BEAT] = sat_add(live_q[4*s+M_RD_BEAT], ar_beats);
            end
            if (aw_hs && (s_axi_awuser == C_DSID_WIDTH'(s))) begin
                live_nxt[4*s+M_WR_REQ]  = sat_add(live_q[4*s+M_WR_REQ], 9'd1);
                live_nxt[4*s+M_WR_BEAT] = sat_add(live_q[4*s+M_WR_BEAT], aw_beats);
            end
        end
    end

    // Window counter, live/snapshot counters and the IDLE/EMIT FSM.
    // The record outputs are loaded one cycle ahead: the window-end edge
    // loads record 0, so the first record is already on the bus in the
    // cycle after the window end.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= S_IDLE;
            wc_q      <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
            vld_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            for (int i = 0; i < NUM_REC; i++) begin
                live_q[i] <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            wc_q <= win_end ? '0 : wc_q + WC_W'(1);

            for (int i = 0; i < NUM_REC; i++) begin
                live_q[i] <= live_nxt[i];
            end

            case (state_q)
                S_IDLE: begin
                    vld_q <= 1'b0;
                    if (win_end) begin
                        // Snapshot includes the window-end cycle's events;
                        // the clear below overrides the accumulate above.
                        for (int i = 0; i < NUM_REC; i++) begin
                            snap_q[i] <= live_nxt[i];
                            live_q[i] <= '0;
                        end
                        idx_q   <= '0;
                        state_q <= S_EMIT;
                        vld_q   <= 1'b1;
                        addr_q  <= C_APM_BASE;
                        data_q  <= live_nxt[0];
                    end
                end
                S_EMIT: begin
                    // A window end here is not snapshotted: live counters
                    // keep accumulating into the next window and the
                    // running emission is left untouched.
                    if (win_end) begin
                        overrun_q <= 1'b1;
                    end
                    if (idx_q == IDX_W'(NUM_REC - 1)) begin
                        state_q <= S_IDLE;
                        vld_q   <= 1'b0;
                    end else begin
                        idx_q  <= idx_nxt;
                        vld_q  <= 1'b1;
                        addr_q <= C_APM_BASE + 32'({idx_nxt, 2'b00});
                        data_q <= snap_q[idx_nxt];
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign APM_VALID = vld_q;
    assign APM_ADDR  = addr_q;
    assign APM_DATA  = data_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_mig_apm_stat_gen.sv
// -----------------------------------------------------------------------------
// Bench for mig_apm_stat_gen.
// dut_a: 4 slots, 64-cycle window, base 0x100 (normal operation, saturation,
//        reset in the middle of an emission).
// dut_b: 4 slots, 8-cycle window, base 0x100 (window ends during emission).
// Both share the snooped-bus inputs; each has its own reset, and only one of
// them is checked at a time. Cycle k of a run is the k-th cycle with its
// reset released; inputs are driven and outputs sampled 1 time unit after
// the rising edge that starts the cycle.
// -----------------------------------------------------------------------------
module tb_mig_apm_stat_gen;

    localparam int          NS   = 4;
    localparam int          NREC = 4 * NS;
    localparam int          WA   = 64;
    localparam int          WB   = 8;
    localparam logic [31:0] BASE = 32'h100;

    // ---------------- clock / reset ----------------
    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic a_rstn;
    logic b_rstn;

    // ---------------- shared snooped bus ----------------
    logic        awv, awr, arv, arr;
    logic [15:0] awu, aru;
    logic [7:0]  awl, arl;

    logic        a_vld, b_vld, a_ovr, b_ovr;
    logic [31:0] a_addr, a_data, b_addr, b_data;

    mig_apm_stat_gen #(
        .C_DSID_WIDTH(16), .C_NUM_SLOTS(NS), .C_WINDOW_CYCLES(WA), .C_APM_BASE(BASE)
    ) dut_a (
        .aclk(aclk), .aresetn(a_rstn),
        .s_axi_awvalid(awv), .s_axi_awready(awr), .s_axi_awuser(awu), .s_axi_awlen(awl),
        .s_axi_arvalid(arv), .s_axi_arready(arr), .s_axi_aruser(aru), .s_axi_arlen(arl),
        .APM_VALID(a_vld), .APM_ADDR(a_addr), .APM_DATA(a_data), .overrun(a_ovr)
    );

    mig_apm_stat_gen #(
        .C_DSID_WIDTH(16), .C_NUM_SLOTS(NS), .C_WINDOW_CYCLES(WB), .C_APM_BASE(BASE)
    ) dut_b (
        .aclk(aclk), .aresetn(b_rstn),
        .s_axi_awvalid(awv), .s_axi_awready(awr), .s_axi_awuser(awu), .s_axi_awlen(awl),
        .s_axi_arvalid(arv), .s_axi_arready(arr), .s_axi_aruser(aru), .s_axi_arlen(arl),
        .APM_VALID(b_vld), .APM_ADDR(b_addr), .APM_DATA(b_data), .overrun(b_ovr)
    );

    // ---------------- stimulus table ----------------
    typedef struct {
        int          sel;   // 0: dut_a run, 1: dut_b run
        int          cyc;
        logic        arv;
        logic        arr;
        logic [15:0] artag;
        logic [7:0]  arlen;
        logic        awv;
        logic        awr;
        logic [15:0] awtag;
        logic [7:0]  awlen;
    } evt_t;

    localparam int NEV = 18;
    evt_t ev [NEV];

    // expected snapshots: exp_rec[k] is emitted after window k of dut_a
    // (index 4 = first window after the mid-emission reset)
    logic [31:0] exp_rec [5][NREC];
    logic [31:0] exp_b   [2][NREC];

    int n_chk  = 0;
    int n_fail = 0;

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, c, act, exp);
        end
    endtask

    task automatic apply_events(input int sel, input int c);
        arv = 1'b0; arr = 1'b0; aru = '0; arl = '0;
        awv = 1'b0; awr = 1'b0; awu = '0; awl = '0;
        for (int k = 0; k < NEV; k++) begin
            if (ev[k].sel == sel && ev[k].cyc == c) begin
                arv = ev[k].arv; arr = ev[k].arr; aru = ev[k].artag; arl = ev[k].arlen;
                awv = ev[k].awv; awr = ev[k].awr; awu = ev[k].awtag; awl = ev[k].awlen;
            end
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // wbase selects which row of exp_rec the first window of this run maps to
    task automatic check_a(input int c, input int wbase);
        bit e;
        int idx;
        e   = (c >= WA) && ((c % WA) < NREC);
        idx = c % WA;
        chk("a_valid", c, 32'(a_vld), 32'(e));
        if (e) begin
            chk("a_addr", c, a_addr, BASE + 32'(4 * idx));
            chk("a_data", c, a_data, exp_rec[wbase + c / WA - 1][idx]);
        end
        chk("a_overrun", c, 32'(a_ovr), 32'd0);
    endtask

    task automatic check_b(input int c);
        bit e;
        int idx;
        int w;
        e   = (c >= 8 && c <= 23) || (c >= 32 && c <= 47);
        w   = (c <= 23) ? 0 : 1;
        idx = (c <= 23) ? c - 8 : c - 32;
        chk("b_valid", c, 32'(b_vld), 32'(e));
        if (e) begin
            chk("b_addr", c, b_addr, BASE + 32'(4 * idx));
            chk("b_data", c, b_data, exp_b[w][idx]);
        end
        chk("b_overrun", c, 32'(b_ovr), 32'(c >= 16));
    endtask

    // ---------------- test ----------------
    initial begin
        //        sel cyc   arv   arr   artag   arlen  awv   awr   awtag  awlen
        ev[0]  = '{0,  70, 1'b1, 1'b1, 16'd2, 8'd7,   1'b0, 1'b0, 16'd0, 8'd0};
        ev[1]  = '{0,  71, 1'b1, 1'b1, 16'd2, 8'd7,   1'b1, 1'b1, 16'd2, 8'd0};
        ev[2]  = '{0,  72, 1'b1, 1'b1, 16'd2, 8'd7,   1'b0, 1'b0, 16'd0, 8'd0};
        ev[3]  = '{0,  80, 1'b1, 1'b1, 16'd0, 8'd15,  1'b0, 1'b0, 16'd0, 8'd0};
        ev[4]  = '{0, 127, 1'b1, 1'b1, 16'd3, 8'd1,   1'b0, 1'b0, 16'd0, 8'd0};  // window-end cycle
        ev[5]  = '{0, 128, 1'b0, 1'b0, 16'd0, 8'd0,   1'b1, 1'b1, 16'd3, 8'd3};  // first cycle of next window
        ev[6]  = '{0, 130, 1'b1, 1'b1, 16'd1, 8'd0,   1'b1, 1'b1, 16'd1, 8'd1};  // same slot, same cycle
        ev[7]  = '{0, 132, 1'b1, 1'b1, 16'd5, 8'd9,   1'b0, 1'b0, 16'd0, 8'd0};  // out-of-range tag
        ev[8]  = '{0, 134, 1'b1, 1'b0, 16'd0, 8'd4,   1'b1, 1'b0, 16'd0, 8'd4};  // valid without ready
        ev[9]  = '{0, 136, 1'b0, 1'b1, 16'd0, 8'd4,   1'b0, 1'b1, 16'd0, 8'd4};  // ready without valid
        ev[10] = '{0, 150, 1'b1, 1'b1, 16'd3, 8'd255, 1'b0, 1'b0, 16'd0, 8'd0};  // saturating add
        ev[11] = '{0, 151, 1'b1, 1'b1, 16'd3, 8'd0,   1'b0, 1'b0, 16'd0, 8'd0};  // hold at max
        ev[12] = '{0, 200, 1'b1, 1'b1, 16'd0, 8'd2,   1'b0, 1'b0, 16'd0, 8'd0};
        ev[13] = '{0, 258, 1'b1, 1'b1, 16'd1, 8'd0,   1'b0, 1'b0, 16'd0, 8'd0};  // discarded by reset
        ev[14] = '{1,   2, 1'b1, 1'b1, 16'd0, 8'd3,   1'b0, 1'b0, 16'd0, 8'd0};
        ev[15] = '{1,  10, 1'b0, 1'b0, 16'd0, 8'd0,   1'b1, 1'b1, 16'd2, 8'd1};
        ev[16] = '{1,  18, 1'b0, 1'b0, 16'd0, 8'd0,   1'b1, 1'b1, 16'd2, 8'd0};
        ev[17] = '{1,  26, 1'b1, 1'b1, 16'd1, 8'd0,   1'b0, 1'b0, 16'd0, 8'd0};

        for (int w = 0; w < 5; w++)
            for (int i = 0; i < NREC; i++) exp_rec[w][i] = 32'd0;
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < NREC; i++) exp_b[w][i] = 32'd0;
        // window 1 (cycles 64..127)
        exp_rec[1][0]  = 32'd1;  exp_rec[1][2]  = 32'd16;
        exp_rec[1][8]  = 32'd3;  exp_rec[1][9]  = 32'd1;
        exp_rec[1][10] = 32'd24; exp_rec[1][11] = 32'd1;
        exp_rec[1][12] = 32'd1;  exp_rec[1][14] = 32'd2;
        // window 2 (cycles 128..191)
        exp_rec[2][4]  = 32'd1;  exp_rec[2][5]  = 32'd1;
        exp_rec[2][6]  = 32'd1;  exp_rec[2][7]  = 32'd2;
        exp_rec[2][12] = 32'd2;  exp_rec[2][13] = 32'd1;
        exp_rec[2][14] = 32'hFFFF_FFFF; exp_rec[2][15] = 32'd4;
        // window 3 (cycles 192..255)
        exp_rec[3][0]  = 32'd1;  exp_rec[3][2]  = 32'd3;
        // dut_b: snapshot at cycle 7, then at cycle 31 (accumulated 8..31)
        exp_b[0][0]    = 32'd1;  exp_b[0][2]    = 32'd4;
        exp_b[1][4]    = 32'd1;  exp_b[1][6]    = 32'd1;
        exp_b[1][9]    = 32'd2;  exp_b[1][11]   = 32'd3;

        a_rstn = 1'b0;
        b_rstn = 1'b0;
        apply_events(-1, -1);
        repeat (3) @(posedge aclk);
        #1;

        chk("a_reset_valid",   -1, 32'(a_vld), 32'd0);
        chk("a_reset_addr",    -1, a_addr,     32'd0);
        chk("a_reset_data",    -1, a_data,     32'd0);
        chk("a_reset_overrun", -1, 32'(a_ovr), 32'd0);
        chk("b_reset_valid",   -1, 32'(b_vld), 32'd0);
        chk("b_reset_overrun", -1, 32'(b_ovr), 32'd0);

        // dut_a run: idle window, counting, boundaries, saturation,
        // then reset during record 5 of the fourth emission (cycle 261)
        a_rstn = 1'b1;
        for (int c = 0; c <= 261; c++) begin
            if (c > 0) step();
            apply_events(0, c);
            if (c == 150) dut_a.live_q[14] = 32'hFFFF_FFF0;
            check_a(c, 0);
        end
        a_rstn = 1'b0;
        step();
        apply_events(-1, -1);
        chk("a_abort_valid",   262, 32'(a_vld), 32'd0);
        chk("a_abort_addr",    262, a_addr,     32'd0);
        chk("a_abort_data",    262, a_data,     32'd0);
        chk("a_abort_overrun", 262, 32'(a_ovr), 32'd0);

        // release: first emission after reset must be all-zero at cycles 64..79
        step();
        a_rstn = 1'b1;
        for (int c = 0; c <= 80; c++) begin
            if (c > 0) step();
            apply_events(-1, -1);
            check_a(c, 4);
        end

        // dut_b run: window end at cycle 15 and 23 fall inside emissions
        step();
        b_rstn = 1'b1;
        for (int c = 0; c <= 47; c++) begin
            if (c > 0) step();
            apply_events(1, c);
            check_b(c);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
